i2c_passthru_dir_ctrl: RTL and testbench
========================================

Name: i2c_passthru_dir_ctrl

Overview:
Per-bit direction sequencer for the I2C passthrough. Tracks START/STOP, bit and byte position, the R/W bit and ACK/NACK outcomes, and tells the bit transmitter for each bit whether it drives toward the master or the slave. It sits between the bus-condition detector / bit receiver and the bit transmitter. It aborts on transmitter violation or bus stall.

Parameters:
F_REF_T_TIMEOUT, 255, number of i_f_ref rising edges without a completed bit (while not idle) before abort
WIDTH_F_REF_T_TIMEOUT, 8, CEILING(LOG2(F_REF_T_TIMEOUT+1))

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_f_ref  in  1  periodic timing reference; rising edges counted
i_start_det  in  1  1-cycle pulse: START or repeated START seen
i_stop_det  in  1  1-cycle pulse: STOP seen
i_bit_valid  in  1  1-cycle pulse: a bit completed (SCL fell after high phase)
i_bit_val  in  1  sampled SDA value of the completed bit, valid with i_bit_valid
i_violation  in  1  level from bit transmitter
o_start_tx  out  1  1-cycle pulse: start next bit transfer
o_tx_is_to_mst  out  1  direction of next bit (1 = slave drives toward master)
o_bit_cnt  out  4  bit index within current 9-bit frame, 0..8
o_addr  out  7  captured 7-bit address
o_rw  out  1  captured R/W bit (1 = read)
o_nack  out  1  level: last ACK slot was NACK; cleared on START
o_busy  out  1  high in every state except IDLE
o_abort  out  1  high in ABORT state

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, bit_cnt 0, shift register 0, timeout counter 0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP, ABORT.
- Event priority, evaluated each cycle: i_stop_det > i_start_det > i_violation > timeout > i_bit_valid.
- i_stop_det in any state -> IDLE; bit_cnt cleared; o_nack and o_addr hold.
- i_start_det in any state, including ABORT -> ADDR; bit_cnt=0; o_nack=0; o_start_tx pulses the next cycle with o_tx_is_to_mst=0.
- i_violation in any busy state -> ABORT. Timeout expiry -> ABORT. ABORT is exited only by START, STOP or reset; no o_start_tx while in ABORT.
- On i_bit_valid, the registered outputs update in the same edge. o_start_tx pulses exactly 1 cycle later, except in IDLE, ABORT and WAIT_STOP. o_tx_is_to_mst is valid from the edge of the update until the next update.
- ADDR: shift i_bit_val MSB-first on each bit.
  - bit_cnt 0..6 fill o_addr; bit_cnt 7 latches o_rw.
  - After bit 7 -> ADDR_ACK; direction=1, bit_cnt=8.
- ADDR_ACK: on bit, o_nack=i_bit_val.
  - NACK -> WAIT_STOP.
  - ACK with rw=0 -> WR_DATA, direction 0.
  - ACK with rw=1 -> RD_DATA, direction 1.
  - bit_cnt=0 in all cases.
- WR_DATA: 8 bits, direction 0 -> WR_ACK, direction 1. WR_ACK: NACK -> WAIT_STOP; ACK -> WR_DATA.
- RD_DATA: 8 bits, direction 1 -> RD_ACK, direction 0. RD_ACK: master ACK (0) -> RD_DATA; master NACK (1) -> WAIT_STOP.
- WAIT_STOP: direction 0; further bits are ignored (no o_start_tx); waits for START/STOP.
- bit_cnt increments mod 9; it never exceeds 8 and wraps to 0 at each byte boundary.
- Timeout counter:
  - Reloads to F_REF_T_TIMEOUT on i_bit_valid, START, or when IDLE.
  - Decrements on each i_f_ref rising edge (prev-sample edge detect) while busy and not ABORT; saturates at 0.
  - Reaching 0 is the timeout event.
- Simultaneous i_bit_valid with i_start_det: START wins and the bit is discarded.

Test Plan:
- Write 0x50 + 2 data bytes, all ACK: START, bits 1010000 0, ACK 0, 8 bits, ACK, 8 bits, ACK, STOP -> o_addr=0x50, o_rw=0; o_tx_is_to_mst 1 only at bit_cnt 8; 27 o_start_tx pulses; IDLE after STOP.
- Read from 0x3C, 2 bytes, master ACK then NACK -> o_rw=1; direction 1 for data bits, 0 for master ACK slots; after the NACK, WAIT_STOP with no further o_start_tx; o_nack=1.
- Address NACK (ACK bit=1) -> WAIT_STOP, o_nack=1; next START clears o_nack and pulses o_start_tx with direction 0.
- Repeated START mid write byte (bit_cnt=4) -> ADDR, bit_cnt=0; simultaneous i_bit_valid ignored.
- i_violation asserted during RD_DATA -> o_abort=1, o_busy=1, no o_start_tx; STOP -> IDLE, o_abort=0.
- No i_bit_valid for 255 i_f_ref edges in WR_DATA -> ABORT; async i_rstn assert mid-ABORT -> all outputs 0 immediately.

Source files
------------

// File: rtl/i2c_passthru_dir_ctrl.sv
// Per-bit direction sequencer for the I2C passthrough: follows START/STOP, address,
// R/W and ACK slots, and tells the bit transmitter which side drives each bit.
module i2c_passthru_dir_ctrl #(
  parameter int unsigned F_REF_T_TIMEOUT       = 255,
  parameter int unsigned WIDTH_F_REF_T_TIMEOUT = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_f_ref,
  input  logic       i_start_det,
  input  logic       i_stop_det,
  input  logic       i_bit_valid,
  input  logic       i_bit_val,
  input  logic       i_violation,
  output logic       o_start_tx,
  output logic       o_tx_is_to_mst,
  output logic [3:0] o_bit_cnt,
  output logic [6:0] o_addr,
  output logic       o_rw,
  output logic       o_nack,
  output logic       o_busy,
  output logic       o_abort
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP,
    S_ABORT
  } state_e;

  localparam logic [WIDTH_F_REF_T_TIMEOUT-1:0] TMO_RELOAD =
    WIDTH_F_REF_T_TIMEOUT'(F_REF_T_TIMEOUT);

  state_e                             state_q;
  logic                               start_tx_q;
  logic                               pend_q;
  logic                               dir_q;
  logic [3:0]                         bit_cnt_q;
  logic [6:0]                         addr_q;
  logic                               rw_q;
  logic                               nack_q;
  logic                               busy_q;
  logic                               abort_q;
  logic                               f_ref_q;
  logic [WIDTH_F_REF_T_TIMEOUT-1:0]   tmo_q;

  logic f_ref_rise_d;
  logic tmo_hit_d;
  logic last_data_bit_d;

  assign f_ref_rise_d    = i_f_ref & ~f_ref_q;
  assign tmo_hit_d       = (state_q != S_IDLE) && (state_q != S_ABORT) && (tmo_q == '0);
  assign last_data_bit_d = (bit_cnt_q == 4'd7);

  // pend_q marks "a bit was just accepted"; o_start_tx follows it one cycle later,
  // so any STOP/abort arriving in between cancels the pulse.
  // NOTE: every register here is assigned with <= so all next-state terms read
  // the pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      start_tx_q <= 1'b0;
      pend_q     <= 1'b0;
      dir_q      <= 1'b0;
      bit_cnt_q  <= 4'd0;
      addr_q     <= 7'd0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      f_ref_q    <= 1'b0;
      tmo_q      <= '0;
    end else begin
      f_ref_q    <= i_f_ref;
      start_tx_q <= 1'b0;

      if (state_q == S_IDLE || i_bit_valid || i_start_det) begin
        tmo_q <= TMO_RELOAD;
      end else if (f_ref_rise_d && state_q != S_ABORT && tmo_q != '0) begin
        tmo_q <= tmo_q - WIDTH_F_REF_T_TIMEOUT'(1);
      end

      if (i_stop_det) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 4'd0;
        dir_q     <= 1'b0;
        pend_q    <= 1'b0;
        busy_q    <= 1'b0;
        abort_q   <= 1'b0;
      end else if (i_start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= 4'd0;
        nack_q    <= 1'b0;
        dir_q     <= 1'b0;
        pend_q    <= 1'b1;
        busy_q    <= 1'b1;
        abort_q   <= 1'b0;
      end else if ((state_q != S_IDLE && i_violation) || tmo_hit_d) begin
        state_q <= S_ABORT;
        pend_q  <= 1'b0;
        busy_q  <= 1'b1;
        abort_q <= 1'b1;
      end else begin
        start_tx_q <= pend_q;
        pend_q     <= 1'b0;
        if (i_bit_valid) begin
          unique case (state_q)
            S_ADDR: begin
              pend_q <= 1'b1;
              if (last_data_bit_d) begin
                rw_q      <= i_bit_val;
                state_q   <= S_ADDR_ACK;
                bit_cnt_q <= 4'd8;
                dir_q     <= 1'b1;
              end else begin
                addr_q    <= {addr_q[5:0], i_bit_val};
                bit_cnt_q <= bit_cnt_q + 4'd1;
                dir_q     <= 1'b0;
              end
            end
            S_ADDR_ACK: begin
              nack_q    <= i_bit_val;
              bit_cnt_q <= 4'd0;
              if (i_bit_val) begin
                state_q <= S_WAIT_STOP;
                dir_q   <= 1'b0;
              end else begin
                state_q <= rw_q ? S_RD_DATA : S_WR_DATA;
                dir_q   <= rw_q;
                pend_q  <= 1'b1;
              end
            end
            S_WR_DATA: begin
              pend_q <= 1'b1;
              if (last_data_bit_d) begin
                state_q   <= S_WR_ACK;
                bit_cnt_q <= 4'd8;
                dir_q     <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                dir_q     <= 1'b0;
              end
            end
            S_RD_DATA: begin
              pend_q <= 1'b1;
              if (last_data_bit_d) begin
                state_q   <= S_RD_ACK;
                bit_cnt_q <= 4'd8;
                dir_q     <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                dir_q     <= 1'b1;
              end
            end
            S_WR_ACK, S_RD_ACK: begin
              nack_q    <= i_bit_val;
              bit_cnt_q <= 4'd0;
              if (i_bit_val) begin
                state_q <= S_WAIT_STOP;
                dir_q   <= 1'b0;
              end else begin
                state_q <= (state_q == S_RD_ACK) ? S_RD_DATA : S_WR_DATA;
                dir_q   <= (state_q == S_RD_ACK);
                pend_q  <= 1'b1;
              end
            end
            default: ;  // IDLE, WAIT_STOP and ABORT ignore bits
          endcase
        end
      end
    end
  end

  assign o_start_tx     = start_tx_q;
  assign o_tx_is_to_mst = dir_q;
  assign o_bit_cnt      = bit_cnt_q;
  assign o_addr         = addr_q;
  assign o_rw           = rw_q;
  assign o_nack         = nack_q;
  assign o_busy         = busy_q;
  assign o_abort        = abort_q;

endmodule

// File: tb/tb_i2c_passthru_dir_ctrl.sv
// Directed bench for i2c_passthru_dir_ctrl: write, read, NACK, repeated START,
// violation and timeout scenarios with hand-computed expectations.
module tb_i2c_passthru_dir_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       f_ref, start_det, stop_det, bit_valid, bit_val, violation;
  logic       start_tx, tx_is_to_mst, rw, nack, busy, abort_o;
  logic [3:0] bit_cnt;
  logic [6:0] addr;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  i2c_passthru_dir_ctrl #(.F_REF_T_TIMEOUT(255), .WIDTH_F_REF_T_TIMEOUT(8)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_f_ref       (f_ref),
    .i_start_det   (start_det),
    .i_stop_det    (stop_det),
    .i_bit_valid   (bit_valid),
    .i_bit_val     (bit_val),
    .i_violation   (violation),
    .o_start_tx    (start_tx),
    .o_tx_is_to_mst(tx_is_to_mst),
    .o_bit_cnt     (bit_cnt),
    .o_addr        (addr),
    .o_rw          (rw),
    .o_nack        (nack),
    .o_busy        (busy),
    .o_abort       (abort_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start_tx === 1'b1) pulses <= pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_stop();
    stop_det = 1'b1;
    tick();
    stop_det = 1'b0;
    tick();
  endtask

  // Outputs are updated on the first tick; the pulse follows on the next one.
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_val   = b;
    tick();
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; f_ref = 1'b0; start_det = 1'b0; stop_det = 1'b0;
    bit_valid = 1'b0; bit_val = 1'b0; violation = 1'b0;
    tick(); tick();
    total++;
    if ({start_tx, tx_is_to_mst, bit_cnt, addr, rw, nack, busy, abort_o} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {start_tx, tx_is_to_mst, bit_cnt, addr, rw, nack, busy, abort_o});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [26:0] seq;
    int          p0;
    logic [3:0]  exp_cnt;
    logic        exp_dir;
    seq = {7'h50, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0};
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    total++;
    if ({busy, tx_is_to_mst, bit_cnt} !== {1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL wr_start_state: got %h want %h", {busy, tx_is_to_mst, bit_cnt}, 6'h20);
    end
    tick();
    total++;
    if (start_tx !== 1'b1) begin
      bad++;
      $display("FAIL wr_start_pulse: got %b want 1", start_tx);
    end
    tick();
    p0 = pulses;
    for (int k = 0; k < 27; k++) begin
      send_bit(seq[26-k]);
      exp_cnt = 4'((k + 1) % 9);
      exp_dir = (exp_cnt == 4'd8);
      total++;
      if ({bit_cnt, tx_is_to_mst} !== {exp_cnt, exp_dir}) begin
        bad++;
        $display("FAIL wr_bit%0d cnt/dir: got %0d/%b want %0d/%b", k, bit_cnt, tx_is_to_mst,
                 exp_cnt, exp_dir);
      end
    end
    total++;
    if (pulses - p0 !== 27) begin
      bad++;
      $display("FAIL wr_pulse_count: got %0d want 27", pulses - p0);
    end
    total++;
    if ({addr, rw, nack} !== {7'h50, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL wr_addr_rw_nack: got %h/%b/%b want 50/0/0", addr, rw, nack);
    end
    do_stop();
    total++;
    if ({busy, abort_o, bit_cnt, addr} !== {1'b0, 1'b0, 4'd0, 7'h50}) begin
      bad++;
      $display("FAIL wr_after_stop: busy=%b abort=%b cnt=%0d addr=%h want 0/0/0/50",
               busy, abort_o, bit_cnt, addr);
    end
  endtask

  task automatic test_read();
    logic [26:0] seq;
    int          p0;
    logic [3:0]  exp_cnt;
    logic        exp_dir;
    seq = {7'h3C, 1'b1, 1'b0, 8'h96, 1'b0, 8'h5A, 1'b1};
    do_start();
    p0 = pulses;
    for (int k = 0; k < 27; k++) begin
      send_bit(seq[26-k]);
      exp_cnt = 4'((k + 1) % 9);
      if (k < 7)       exp_dir = 1'b0;
      else if (k == 7) exp_dir = 1'b1;
      else if (k == 26) exp_dir = 1'b0;
      else             exp_dir = (exp_cnt != 4'd8);
      total++;
      if ({bit_cnt, tx_is_to_mst} !== {exp_cnt, exp_dir}) begin
        bad++;
        $display("FAIL rd_bit%0d cnt/dir: got %0d/%b want %0d/%b", k, bit_cnt, tx_is_to_mst,
                 exp_cnt, exp_dir);
      end
    end
    send_bit(1'b0);
    total++;
    if (pulses - p0 !== 26) begin
      bad++;
      $display("FAIL rd_pulse_count: got %0d want 26", pulses - p0);
    end
    total++;
    if ({addr, rw, nack, busy, bit_cnt} !== {7'h3C, 1'b1, 1'b1, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL rd_wait_stop: addr=%h rw=%b nack=%b busy=%b cnt=%0d want 3c/1/1/1/0",
               addr, rw, nack, busy, bit_cnt);
    end
    do_stop();
  endtask

  task automatic test_addr_nack();
    logic [7:0] a;
    a = {7'h22, 1'b0};
    do_start();
    for (int k = 7; k >= 0; k--) send_bit(a[k]);
    send_bit(1'b1);
    total++;
    if ({nack, busy, bit_cnt, tx_is_to_mst} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL nack_wait_stop: nack=%b busy=%b cnt=%0d dir=%b want 1/1/0/0",
               nack, busy, bit_cnt, tx_is_to_mst);
    end
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    total++;
    if (nack !== 1'b0) begin
      bad++;
      $display("FAIL nack_cleared_by_start: got %b want 0", nack);
    end
    tick();
    total++;
    if ({start_tx, tx_is_to_mst} !== 2'b10) begin
      bad++;
      $display("FAIL nack_restart_pulse: got %b want 10", {start_tx, tx_is_to_mst});
    end
    tick();
    do_stop();
  endtask

  task automatic test_repeated_start();
    logic [8:0] a;
    logic [7:0] b;
    a = {7'h50, 1'b0, 1'b0};
    b = {7'h3C, 1'b1};
    do_start();
    for (int k = 8; k >= 0; k--) send_bit(a[k]);
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    total++;
    if (bit_cnt !== 4'd4) begin
      bad++;
      $display("FAIL rs_mid_byte_cnt: got %0d want 4", bit_cnt);
    end
    start_det = 1'b1;
    bit_valid = 1'b1;
    bit_val   = 1'b1;
    tick();
    start_det = 1'b0;
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    total++;
    if ({bit_cnt, tx_is_to_mst, busy} !== {4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rs_restart_state: cnt=%0d dir=%b busy=%b want 0/0/1",
               bit_cnt, tx_is_to_mst, busy);
    end
    tick();
    total++;
    if (start_tx !== 1'b1) begin
      bad++;
      $display("FAIL rs_restart_pulse: got %b want 1", start_tx);
    end
    tick();
    for (int k = 7; k >= 0; k--) send_bit(b[k]);
    total++;
    if ({addr, rw, bit_cnt, tx_is_to_mst} !== {7'h3C, 1'b1, 4'd8, 1'b1}) begin
      bad++;
      $display("FAIL rs_new_addr: addr=%h rw=%b cnt=%0d dir=%b want 3c/1/8/1",
               addr, rw, bit_cnt, tx_is_to_mst);
    end
    do_stop();
  endtask

  task automatic test_violation();
    logic [8:0] a;
    int         p0;
    a = {7'h3C, 1'b1, 1'b0};
    do_start();
    for (int k = 8; k >= 0; k--) send_bit(a[k]);
    send_bit(1'b1);
    send_bit(1'b0);
    violation = 1'b1;
    tick();
    total++;
    if ({abort_o, busy} !== 2'b11) begin
      bad++;
      $display("FAIL viol_abort: abort=%b busy=%b want 1/1", abort_o, busy);
    end
    p0 = pulses;
    send_bit(1'b1);
    violation = 1'b0;
    send_bit(1'b0);
    total++;
    if (pulses - p0 !== 0 || abort_o !== 1'b1) begin
      bad++;
      $display("FAIL viol_no_pulse: pulses=%0d abort=%b want 0/1", pulses - p0, abort_o);
    end
    do_stop();
    total++;
    if ({abort_o, busy} !== 2'b00) begin
      bad++;
      $display("FAIL viol_stop_idle: abort=%b busy=%b want 0/0", abort_o, busy);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] a;
    a = {7'h50, 1'b0, 1'b0};
    do_start();
    for (int k = 8; k >= 0; k--) send_bit(a[k]);
    for (int i = 0; i < 254; i++) begin
      f_ref = 1'b1; tick();
      f_ref = 1'b0; tick();
    end
    total++;
    if ({abort_o, busy} !== 2'b01) begin
      bad++;
      $display("FAIL tmo_254_edges: abort=%b busy=%b want 0/1", abort_o, busy);
    end
    f_ref = 1'b1; tick();
    f_ref = 1'b0; tick();
    total++;
    if ({abort_o, busy} !== 2'b11) begin
      bad++;
      $display("FAIL tmo_255_edges: abort=%b busy=%b want 1/1", abort_o, busy);
    end
    tick();
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({start_tx, tx_is_to_mst, bit_cnt, addr, rw, nack, busy, abort_o} !== 17'd0) begin
      bad++;
      $display("FAIL tmo_async_reset: got %h want 0",
               {start_tx, tx_is_to_mst, bit_cnt, addr, rw, nack, busy, abort_o});
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_repeated_start();
    test_violation();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
